// File: rtl/nn_pkg.sv
// Shared network constants and the digit detector state type.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } detect_state_t;

    localparam int unsigned NUM_OUTPUTS  = 10;
    localparam logic [4:0]  L2_BASE_ADDR = 5'd8;
    localparam logic [3:0]  NO_DIGIT     = 4'hF;
    localparam int unsigned SIG_W        = 4;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear that wraps to zero after rollover_val.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= '0;
            end else begin
                count_out <= count_out + 1'b1;
            end
        end
    end

    // High during the counting cycle that will wrap back to zero.
    assign rollover_flag = count_enable && (count_out == rollover_val);

endmodule

// File: rtl/digit_detector.sv
// Scans the output-layer sigmoid registers for the argmax and reports the recognised digit.
module digit_detector
    import nn_pkg::*;
#(
    parameter int unsigned NUM_OUTPUTS = nn_pkg::NUM_OUTPUTS,
    parameter int unsigned BASE_ADDR   = nn_pkg::L2_BASE_ADDR,
    parameter int unsigned DATA_W      = nn_pkg::SIG_W,
    parameter int unsigned ADDR_W      = 5,
    parameter int          MIN_CONF    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              network_done,
    input  logic [DATA_W-1:0] sig_data,
    output logic [ADDR_W-1:0] sig_addr,
    output logic              busy,
    output logic [3:0]        digit,
    output logic [DATA_W-1:0] confidence,
    output logic              digit_valid
);

    detect_state_t     state, next_state;
    logic [3:0]        idx;
    logic              last;
    logic              start;
    logic [DATA_W-1:0] best_val;
    logic [3:0]        best_idx;
    logic              better;
    logic [DATA_W-1:0] winner_val;
    logic [3:0]        winner_idx;

    assign start = (state == IDLE) && network_done;

    flex_counter #(
        .NUM_CNT_BITS(4)
    ) u_idx (
        .clk          (clk),
        .rst          (rst),
        .clear        (start),
        .count_enable (state == SCAN),
        .rollover_val (4'(NUM_OUTPUTS - 1)),
        .count_out    (idx),
        .rollover_flag(last)
    );

    // Strict compare keeps the lowest index on ties.
    assign better     = sig_data > best_val;
    assign winner_val = better ? sig_data : best_val;
    assign winner_idx = better ? idx : best_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        busy        = 1'b0;
        sig_addr    = '0;
        digit_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (network_done) next_state = SCAN;
            end
            SCAN: begin
                busy     = 1'b1;
                sig_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
                if (last) next_state = REPORT;
            end
            REPORT: begin
                digit_valid = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_val   <= '0;
            best_idx   <= '0;
            digit      <= NO_DIGIT;
            confidence <= '0;
        end else if (start) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (state == SCAN) begin
            best_val <= winner_val;
            best_idx <= winner_idx;
            if (last) begin
                // Signed compare so a zero threshold is not a constant-true unsigned test.
                digit      <= (int'(winner_val) >= MIN_CONF) ? winner_idx : NO_DIGIT;
                confidence <= winner_val;
            end
        end
    end

endmodule

// File: tb/tb_digit_detector.sv
// Directed bench for digit_detector: default build plus a MIN_CONF=8 build sharing one register file.
module tb_digit_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       nd0, nd1;
    logic [3:0] mem [32];
    logic [3:0] sd0, sd1;
    logic [4:0] a0, a1;
    logic       busy0, busy1, dv0, dv1;
    logic [3:0] dg0, dg1, cf0, cf1;

    int total = 0;
    int bad   = 0;

    logic [31:0] busy_s, addr_s, dv_s, dg_s, cf_s;

    always #5 clk = ~clk;

    assign sd0 = mem[a0];
    assign sd1 = mem[a1];

    digit_detector u0 (
        .clk(clk), .rst(rst), .network_done(nd0), .sig_data(sd0), .sig_addr(a0),
        .busy(busy0), .digit(dg0), .confidence(cf0), .digit_valid(dv0)
    );

    digit_detector #(.MIN_CONF(8)) u1 (
        .clk(clk), .rst(rst), .network_done(nd1), .sig_data(sd1), .sig_addr(a1),
        .busy(busy1), .digit(dg1), .confidence(cf1), .digit_valid(dv1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int d);
        busy_s = (d == 0) ? 32'(busy0) : 32'(busy1);
        addr_s = (d == 0) ? 32'(a0)    : 32'(a1);
        dv_s   = (d == 0) ? 32'(dv0)   : 32'(dv1);
        dg_s   = (d == 0) ? 32'(dg0)   : 32'(dg1);
        cf_s   = (d == 0) ? 32'(cf0)   : 32'(cf1);
    endtask

    task automatic set_nd(input int d, input logic v);
        if (d == 0) nd0 = v;
        else        nd1 = v;
    endtask

    // Nibble i of p is the value for output neuron i.
    task automatic load(input logic [39:0] p);
        for (int i = 0; i < 10; i++) mem[8+i] = p[i*4 +: 4];
    endtask

    task automatic check_reset_state(input int d);
        sample(d);
        chk("rst_digit", dg_s, 32'hF);
        chk("rst_conf", cf_s, 0);
        chk("rst_valid", dv_s, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_addr", addr_s, 0);
    endtask

    task automatic run(input int d, input logic [3:0] ed, input logic [3:0] ec);
        set_nd(d, 1'b1);
        sample(d);
        chk("c0_busy", busy_s, 0);
        tick();
        set_nd(d, 1'b0);
        for (int k = 0; k < 10; k++) begin
            sample(d);
            chk("scan_busy", busy_s, 1);
            chk("scan_addr", addr_s, 32'(8 + k));
            chk("scan_valid", dv_s, 0);
            tick();
        end
        sample(d);
        chk("rep_valid", dv_s, 1);
        chk("rep_busy", busy_s, 0);
        chk("rep_digit", dg_s, 32'(ed));
        chk("rep_conf", cf_s, 32'(ec));
        tick();
        sample(d);
        chk("post_valid", dv_s, 0);
        chk("hold_digit", dg_s, 32'(ed));
        chk("hold_conf", cf_s, 32'(ec));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 4'h0;
        rst = 1'b1;
        nd0 = 1'b0;
        nd1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state held over idle cycles.
        for (int c = 0; c < 5; c++) begin
            check_reset_state(0);
            check_reset_state(1);
            tick();
        end

        // Basic argmax.
        load(40'h23C7654321);
        run(0, 4'd7, 4'd12);
        for (int c = 0; c < 5; c++) begin
            tick();
            sample(0);
            chk("held_digit", dg_s, 7);
            chk("held_conf", cf_s, 12);
            chk("held_valid", dv_s, 0);
        end

        // Ties and all-zero.
        load(40'h9000090090);
        run(0, 4'd1, 4'd9);
        tick();
        load(40'h0000000000);
        run(0, 4'd0, 4'd0);
        tick();

        // Threshold build: max below MIN_CONF reports NO_DIGIT but still strobes.
        load(40'h0012345021);
        run(1, 4'hF, 4'd5);
        tick();

        // Extra pulses during SCAN (cycle 4) and REPORT (cycle 11) are ignored.
        load(40'h00000000B2);
        nd0 = 1'b1;
        tick();
        for (int c = 1; c <= 13; c++) begin
            nd0 = (c == 4 || c == 11);
            sample(0);
            chk("ign_valid", dv_s, 32'(c == 11));
            chk("ign_busy", busy_s, 32'(c >= 1 && c <= 10));
            tick();
        end
        nd0 = 1'b0;
        sample(0);
        chk("ign_digit", dg_s, 1);
        chk("ign_conf", cf_s, 11);

        // Reset in cycle 6 of a scan aborts it.
        load(40'hFFFFFFFFFF);
        nd0 = 1'b1;
        tick();
        nd0 = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state(0);
        for (int c = 0; c < 12; c++) begin
            tick();
            sample(0);
            chk("abort_valid", dv_s, 0);
            chk("abort_digit", dg_s, 32'hF);
        end

        // Back-to-back runs 256 cycles apart.
        load(40'hE111111111);
        run(0, 4'd9, 4'd14);
        load(40'h5555555557);
        for (int c = 0; c < 243; c++) begin
            tick();
            sample(0);
            if (dv_s !== 0 || dg_s !== 9 || cf_s !== 14) begin
                chk("b2b_hold", {dv_s[3:0], dg_s[3:0], cf_s[3:0]}, 32'h09E);
            end
        end
        sample(0);
        chk("b2b_hold_end", {dv_s[3:0], dg_s[3:0], cf_s[3:0]}, 32'h09E);
        tick();
        run(0, 4'd0, 4'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_detector.md
Name: digit_detector

Overview:
Consumes the ten output-layer sigmoid results that the network controller writes into the sigmoid register file (addresses BASE_ADDR..BASE_ADDR+9). Starts on the controller's one-cycle network_done pulse. Scans the ten values and finds the argmax, which is the recognised digit. Presents digit and confidence to the SPI output stage with a one-cycle valid strobe, and holds the result until the next detection completes.

Parameters:
NUM_OUTPUTS, 10, number of output neurons scanned
BASE_ADDR, 8, sigmoid register address of output neuron 0
DATA_W, 4, sigmoid value width
ADDR_W, 5, sigmoid register address width
MIN_CONF, 0, minimum max-value for a valid detection; a max below it reports NO_DIGIT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
network_done  input  1  one-cycle pulse: output layer written, start scan
sig_data  input  DATA_W  sigmoid register read data, combinational from sig_addr, same cycle
sig_addr  output  ADDR_W  sigmoid register read address
busy  output  1  high while scanning; the top level muxes sig_addr onto the register file when busy=1
digit  output  4  detected digit 0..9, or NO_DIGIT (4'hF)
confidence  output  DATA_W  sigmoid value of the winning neuron
digit_valid  output  1  one-cycle strobe: new digit/confidence valid

Behaviour:
- Only clk and rst are used: one clock, synchronous active-high reset. rst high at a rising edge forces the reset state next cycle, overriding everything else.
- Reset values: digit=4'hF, confidence=0, digit_valid=0, busy=0, sig_addr=0, state=IDLE, idx=0, best_val=0, best_idx=0.
- FSM states: IDLE, SCAN, REPORT.
- IDLE:
  - sig_addr=0, busy=0.
  - network_done=1 → SCAN; idx:=0, best_val:=0, best_idx:=0.
- SCAN:
  - busy=1, sig_addr=BASE_ADDR+idx (zero-extended add, ADDR_W bits).
  - Each cycle, if sig_data > best_val (strict, unsigned): best_val:=sig_data, best_idx:=idx.
  - idx increments by 1 per cycle.
  - When idx==NUM_OUTPUTS-1, that cycle's compare is folded into the final result:
    - digit:=winner_idx if winner_val>=MIN_CONF, else 4'hF;
    - confidence:=winner_val;
    - idx:=0, → REPORT.
- REPORT: digit_valid=1, busy=0, → IDLE unconditionally.
- Latency: network_done high in cycle 0; SCAN occupies cycles 1..10; digit_valid high in cycle 11 only. digit/confidence change only at the cycle-10→11 edge and hold until the next detection.
- Ties: lowest index wins (strict >). All-zero inputs give digit=0, confidence=0 when MIN_CONF=0.
- network_done during SCAN or REPORT is ignored (not queued). The controller guarantees ≥256 cycles between pulses.
- rst during SCAN: scan aborts, outputs return to reset values, and no digit_valid is issued.
- digit_valid and network_done in the same cycle: the strobe completes and the new pulse is ignored (state is REPORT).
- sig_data is sampled only in SCAN. Its value outside SCAN is don't-care.

Decomposition:
- Shared package nn_pkg holds:
  - typedef detect_state_t {IDLE, SCAN, REPORT};
  - constants NUM_OUTPUTS=10, L2_BASE_ADDR=5'd8, NO_DIGIT=4'hF, SIG_W=4.
  - The network controller's layer-2 base address moves to L2_BASE_ADDR in the same package.
- The idx counter is the existing flex_counter (NUM_CNT_BITS=4, rollover_val=NUM_OUTPUTS-1):
  - clear driven by the IDLE→SCAN transition;
  - count_enable = (state==SCAN).
- The comparator/result registers stay inline. No other sub-module.

Test Plan:
1. Reset, then idle 5 cycles → digit=4'hF, confidence=0, digit_valid=0, busy=0, sig_addr=0 throughout.
2. Register file addr 8..17 = {1,2,3,4,5,6,7,12,3,2}; pulse network_done at cycle 0 → sig_addr steps 8..17 in cycles 1..10, busy=1 in cycles 1..10, digit_valid only in cycle 11, digit=7, confidence=12, held afterwards.
3. Tie: values {0,9,0,0,9,0,0,0,0,9} → digit=1, confidence=9. All zeros → digit=0, confidence=0.
4. MIN_CONF=8 build, values max=5 at index 3 → digit=4'hF, confidence=5, digit_valid still pulses in cycle 11.
5. Second network_done asserted in cycle 4 of a scan → ignored, single digit_valid at cycle 11. rst in cycle 6 of a new scan → no digit_valid, digit returns to 4'hF, busy=0 next cycle.
6. Back-to-back runs 256 cycles apart with different winners (index 9 then index 0) → each run reports its own digit and confidence; result held unchanged between strobes.
